// File: rtl/sweep_sequencer.sv
// Sweep sequencer: loads a WIDTH x DEPTH grid row by row, then commits one external sweep per clock until convergence.
// Optional macro ITER_LIMIT_EN stops the sweep loop once MAX_ITER sweeps have been committed.
module sweep_sequencer #(
   parameter  int WIDTH    = 16,
   parameter  int DEPTH    = 16,
   parameter  int MAX_ITER = 256,
   localparam int CNT_W    = $clog2(WIDTH*DEPTH+1),
   localparam int ITER_W   = $clog2(WIDTH*DEPTH+2),
   localparam int ROW_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   row_valid,
   output logic                   row_ready,
   input  logic [WIDTH-1:0]       row_data,
   output logic [WIDTH*DEPTH-1:0] sweep_grid_o,
   input  logic [WIDTH*DEPTH-1:0] sweep_grid_i,
   input  logic [CNT_W-1:0]       sweep_removed_i,
   input  logic                   sweep_any_i,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       total_removed,
   output logic [ITER_W-1:0]      iterations,
   output logic                   limit_hit
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SWEEP = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ITER_W-1:0] ITER_CEIL = ITER_W'(WIDTH*DEPTH+1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(DEPTH-1);

   state_t              state_r;
   logic [WIDTH*DEPTH-1:0] grid_r;
   logic [ROW_W-1:0]    row_cnt_r;
   logic [ITER_W-1:0]   iter_next_s;

   assign sweep_grid_o = grid_r;

   // Saturating sweep count so the counter can never wrap.
   always_comb begin
      iter_next_s = iterations;
      if (iterations != ITER_CEIL) begin
         iter_next_s = iterations + ITER_W'(1);
      end else begin
         iter_next_s = iterations;
      end
   end

   // Controller FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         grid_r        <= '0;
         row_cnt_r     <= '0;
         row_ready     <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         total_removed <= '0;
         iterations    <= '0;
         limit_hit     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state_r       <= LOAD;
                  row_ready     <= 1'b1;
                  busy          <= 1'b1;
                  row_cnt_r     <= '0;
                  total_removed <= '0;
                  iterations    <= '0;
                  limit_hit     <= 1'b0;
               end
            end
            LOAD: begin
               if (row_valid && row_ready) begin
                  for (int i = 0; i < DEPTH; i++) begin
                     if (row_cnt_r == ROW_W'(i)) begin
                        grid_r[i*WIDTH +: WIDTH] <= row_data;
                     end
                  end
                  // The counter is reloaded at the next start, so it just parks on the last row.
                  if (row_cnt_r == LAST_ROW) begin
                     state_r   <= SWEEP;
                     row_ready <= 1'b0;
                  end else begin
                     row_cnt_r <= row_cnt_r + ROW_W'(1);
                  end
               end
            end
            SWEEP: begin
               grid_r        <= sweep_grid_i;
               total_removed <= total_removed + sweep_removed_i;
               iterations    <= iter_next_s;
               if (!sweep_any_i) begin
                  state_r <= DONE;
                  done    <= 1'b1;
`ifdef ITER_LIMIT_EN
               end else if (32'(iter_next_s) == 32'(MAX_ITER)) begin
                  state_r   <= DONE;
                  done      <= 1'b1;
                  limit_hit <= 1'b1;
`endif
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r   <= IDLE;
               row_ready <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Self-checking bench for sweep_sequencer (4x4): directed cases plus randomized grids and stalls.
// The sweep unit and the reference model both live here; a cell is removed when fewer than 4 of its 8 neighbours are occupied.
module tb_sweep_sequencer;

   localparam int W      = 4;
   localparam int D      = 4;
   localparam int CNT_W  = $clog2(W*D+1);
   localparam int ITER_W = $clog2(W*D+2);
`ifdef ITER_LIMIT_EN
   localparam int  TB_MAX_ITER = 1;
   localparam bit  LIM         = 1'b1;
`else
   localparam int  TB_MAX_ITER = 256;
   localparam bit  LIM         = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              row_valid = 1'b0;
   logic              row_ready;
   logic [W-1:0]      row_data = '0;
   logic [W*D-1:0]    sweep_grid_o;
   logic [W*D-1:0]    sweep_grid_i;
   logic [CNT_W-1:0]  sweep_removed_i;
   logic              sweep_any_i;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  total_removed;
   logic [ITER_W-1:0] iterations;
   logic              limit_hit;

   int checks = 0;
   int errors = 0;

   sweep_sequencer #(.WIDTH(W), .DEPTH(D), .MAX_ITER(TB_MAX_ITER)) dut (
      .clk(clk), .rst(rst), .start(start), .row_valid(row_valid), .row_ready(row_ready),
      .row_data(row_data), .sweep_grid_o(sweep_grid_o), .sweep_grid_i(sweep_grid_i),
      .sweep_removed_i(sweep_removed_i), .sweep_any_i(sweep_any_i), .busy(busy), .done(done),
      .total_removed(total_removed), .iterations(iterations), .limit_hit(limit_hit)
   );

   always #5 clk = ~clk;

   function automatic logic [W*D-1:0] sweep_fn(input logic [W*D-1:0] g);
      logic [W*D-1:0] ng;
      int n;
      ng = g;
      for (int r = 0; r < D; r++) begin
         for (int c = 0; c < W; c++) begin
            if (g[r*W+c]) begin
               n = 0;
               for (int dr = -1; dr <= 1; dr++)
                  for (int dc = -1; dc <= 1; dc++)
                     if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr < D && c+dc >= 0 && c+dc < W)
                        if (g[(r+dr)*W + (c+dc)]) n++;
               if (n < 4) ng[r*W+c] = 1'b0;
            end
         end
      end
      return ng;
   endfunction

   // External sweep unit driven from the controller's grid register.
   always_comb begin
      sweep_grid_i    = sweep_fn(sweep_grid_o);
      sweep_removed_i = CNT_W'($countones(sweep_grid_o) - $countones(sweep_grid_i));
      sweep_any_i     = (sweep_removed_i != '0);
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_run(input logic [W*D-1:0] g0, output int tot, output int it, output int hit);
      logic [W*D-1:0] g, ng;
      int rem;
      g = g0; tot = 0; it = 0; hit = 0;
      forever begin
         ng  = sweep_fn(g);
         rem = $countones(g) - $countones(ng);
         tot += rem;
         it++;
         g = ng;
         if (rem == 0) break;
         if (LIM && it == TB_MAX_ITER) begin
            hit = 1;
            break;
         end
      end
   endtask

   // exp_* < 0 means take the expectation from the reference model.
   task automatic run_job(input string name, input logic [W*D-1:0] g, input int gap_row, input int gap_len,
                          input bit start_in_load, input int exp_tot, input int exp_it, input int exp_hit);
      int cyc, gaps, m_tot, m_it, m_hit;
      model_run(g, m_tot, m_it, m_hit);
      if (exp_tot < 0) begin
         exp_tot = m_tot; exp_it = m_it; exp_hit = m_hit;
      end
      gaps  = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 1;
      check({name, "_ready_c1"}, row_ready, 1);
      check({name, "_busy_c1"}, busy, 1);
      check({name, "_iter_clr"}, iterations, 0);
      for (int i = 0; i < D; i++) begin
         if (i == gap_row) begin
            for (int k = 0; k < gap_len; k++) begin
               row_valid = 1'b0;
               start     = start_in_load;
               tick();
               cyc++; gaps++;
               check({name, "_ready_gap"}, row_ready, 1);
            end
         end
         row_valid = 1'b1;
         row_data  = g[i*W +: W];
         start     = start_in_load && (i == 1);
         tick();
         cyc++;
         start = 1'b0;
      end
      row_valid = 1'b0;
      check({name, "_ready_sweep"}, row_ready, 0);
      check({name, "_grid_loaded"}, int'(sweep_grid_o), int'(g));
      while (!done && cyc < 300) begin
         tick();
         cyc++;
      end
      check({name, "_done_seen"}, done, 1);
      check({name, "_done_cycle"}, cyc, D + 1 + gaps + exp_it);
      check({name, "_total"}, total_removed, exp_tot);
      check({name, "_iters"}, iterations, exp_it);
      check({name, "_limit"}, limit_hit, exp_hit);
      tick();
      check({name, "_done_pulse"}, done, 0);
      check({name, "_idle"}, busy, 0);
      check({name, "_hold"}, total_removed, exp_tot);
   endtask

   initial begin
      logic [W*D-1:0] g;
      int saw_done;
      repeat (2) tick();
      check("rst_ready", row_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_total", total_removed, 0);
      check("rst_iter", iterations, 0);
      check("rst_limit", limit_hit, 0);
      check("rst_grid", int'(sweep_grid_o), 0);
      rst = 1'b0;
      tick();
      check("idle_busy", busy, 0);

      run_job("zero", 16'h0000, -1, 0, 1'b0, 0, 1, 0);
      run_job("ones", 16'hFFFF, -1, 0, 1'b0, 4, LIM ? 1 : 2, LIM ? 1 : 0);
      run_job("single", 16'h0200, -1, 0, 1'b0, 1, LIM ? 1 : 2, LIM ? 1 : 0);
      run_job("gap", 16'hFFFF, 2, 3, 1'b0, 4, LIM ? 1 : 2, LIM ? 1 : 0);

      // Abort in the second SWEEP cycle.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < D; i++) begin
         row_valid = 1'b1;
         row_data  = 4'hF;
         tick();
      end
      row_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_iter", iterations, 0);
      check("abort_grid", int'(sweep_grid_o), 0);
      saw_done = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (done) saw_done = 1;
      end
      check("abort_no_done", saw_done, 0);
      run_job("after_abort", 16'h0000, -1, 0, 1'b1, 0, 1, 0);

      for (int n = 0; n < 24; n++) begin
         g = 16'($urandom) | (n[0] ? 16'($urandom) : 16'h0000);
         run_job("rand", g, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), -1, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
